bram_single_arbiter: RTL and testbench

//   Shares one single-port BRAM (BRAM_SINGLE) between two requesters (port 0, port 1) by round-robin arbitration.

---
 rtl/bram_single_arbiter_pkg.sv | 27 ++
 rtl/bram_single_arbiter_rr_arbiter_2.sv | 37 +++
 rtl/bram_single_arbiter.sv | 160 ++++++++++++++++
 tb/tb_bram_single_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_single_arbiter_pkg.sv
// ============================================================================
// Module      : bram_single_arbiter_pkg
// Description : FSM state encodings, port indices and helpers for the
//               single-port BRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bram_single_arbiter_pkg;

    localparam int         c_state_w   = 3;
    localparam logic [2:0] c_st_init   = 3'd0;
    localparam logic [2:0] c_st_idle   = 3'd1;
    localparam logic [2:0] c_st_grant  = 3'd2;
    localparam logic [2:0] c_st_access = 3'd3;
    localparam logic [2:0] c_st_done   = 3'd4;

    localparam logic c_port0 = 1'b0;
    localparam logic c_port1 = 1'b1;

    function automatic logic other_port(input logic port);
        return ~port;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bram_single_arbiter_rr_arbiter_2.sv
// ============================================================================
// Module      : bram_single_arbiter_rr_arbiter_2
// Description : Two-way round-robin arbiter; owns the priority pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_single_arbiter_rr_arbiter_2
    import bram_single_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic advance,
    input  logic advance_port,
    output logic grant,
    output logic valid
);

    logic r_pointer;

    // After a completed access the port that was just served loses priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pointer <= c_port0;
        end else if (advance) begin
            r_pointer <= other_port(advance_port);
        end
    end

    assign valid = req0 | req1;
    assign grant = (req0 & req1) ? r_pointer : req1;

endmodule

`default_nettype wire

// File: rtl/bram_single_arbiter.sv
// ============================================================================
// Module      : bram_single_arbiter
// Description : Shares one single-port BRAM between two requesters using a
//               grant / access / acknowledge sequence per transaction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_single_arbiter
    import bram_single_arbiter_pkg::*;
#(
    parameter  int BITWIDTH = 12,
    parameter  int RAMWIDTH = 32,
    localparam int AW       = $clog2(RAMWIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                req0,
    input  logic                req1,
    input  logic                we0,
    input  logic                we1,
    input  logic [AW-1:0]       adr0,
    input  logic [AW-1:0]       adr1,
    input  logic [BITWIDTH-1:0] din0,
    input  logic [BITWIDTH-1:0] din1,
    output logic                ack0,
    output logic                ack1,
    output logic                err0,
    output logic                err1,
    output logic [BITWIDTH-1:0] rdata,
    output logic                busy,
    output logic                mem_en,
    output logic                mem_we,
    output logic [AW-1:0]       mem_adr,
    output logic [BITWIDTH-1:0] mem_din,
    input  logic [BITWIDTH-1:0] mem_dout
);

    localparam logic [AW:0] c_ram_limit = (AW+1)'(RAMWIDTH);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_next;
    logic                 r_win;
    logic                 r_we;
    logic [AW-1:0]        r_adr;
    logic [BITWIDTH-1:0]  r_din;
    logic [BITWIDTH-1:0]  r_rdata;
    logic                 r_from_done;
    logic                 r_clr_pend;
    logic                 w_req0;
    logic                 w_req1;
    logic                 w_grant;
    logic                 w_grant_valid;
    logic                 w_illegal;
    logic                 w_done;
    logic                 w_latch;

    // A request still high in the IDLE cycle right after its ACK is stale.
    assign w_req0    = req0 & ~(r_from_done & (r_win == c_port0));
    assign w_req1    = req1 & ~(r_from_done & (r_win == c_port1));
    assign w_illegal = ({1'b0, r_adr} >= c_ram_limit);
    assign w_done    = (r_state == c_st_done);
    assign w_latch   = (r_state == c_st_idle) && (w_next == c_st_grant);

    bram_single_arbiter_rr_arbiter_2 u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0         (w_req0),
        .req1         (w_req1),
        .advance      (w_done),
        .advance_port (r_win),
        .grant        (w_grant),
        .valid        (w_grant_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_init;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_init:   w_next = c_st_idle;
            c_st_idle: begin
                if (r_clr_pend || clr) begin
                    w_next = c_st_init;
                end else if (w_grant_valid) begin
                    w_next = c_st_grant;
                end
            end
            c_st_grant:  w_next = c_st_access;
            c_st_access: w_next = c_st_done;
            c_st_done:   w_next = c_st_idle;
            default:     w_next = c_st_init;
        endcase
    end

    always_comb begin
        ack0   = 1'b0;
        ack1   = 1'b0;
        err0   = 1'b0;
        err1   = 1'b0;
        busy   = 1'b1;
        mem_en = 1'b1;
        mem_we = 1'b0;
        case (r_state)
            c_st_init:   mem_en = 1'b0;
            c_st_idle:   busy   = 1'b0;
            c_st_grant,
            c_st_access: mem_we = r_we & ~w_illegal;
            c_st_done: begin
                ack0 = (r_win == c_port0);
                ack1 = (r_win == c_port1);
                err0 = (r_win == c_port0) & w_illegal;
                err1 = (r_win == c_port1) & w_illegal;
            end
            default: mem_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win       <= c_port0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_din       <= '0;
            r_rdata     <= '0;
            r_from_done <= 1'b0;
            r_clr_pend  <= 1'b0;
        end else begin
            r_from_done <= w_done;
            if (r_state == c_st_init) begin
                r_clr_pend <= 1'b0;
            end else if (clr) begin
                r_clr_pend <= 1'b1;
            end
            if (w_latch) begin
                r_win <= w_grant;
                r_we  <= w_grant ? we1  : we0;
                r_adr <= w_grant ? adr1 : adr0;
                r_din <= w_grant ? din1 : din0;
            end
            if ((r_state == c_st_access) && !r_we && !w_illegal) begin
                r_rdata <= mem_dout;
            end
        end
    end

    assign rdata   = r_rdata;
    assign mem_adr = r_adr;
    assign mem_din = r_din;

endmodule

`default_nettype wire

// File: tb/tb_bram_single_arbiter.sv
// ============================================================================
// Module      : tb_bram_single_arbiter
// Description : Scoreboard bench for bram_single_arbiter with a behavioural
//               BRAM; a second instance uses a non-power-of-2 depth.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_single_arbiter;

    typedef struct {
        logic        port;
        logic        err;
        logic        chk;
        logic [11:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr      [2];
    logic        req      [2][2];
    logic        wen      [2][2];
    logic [4:0]  adr      [2][2];
    logic [11:0] din      [2][2];
    logic        ack      [2][2];
    logic        err      [2][2];
    logic [11:0] rdata    [2];
    logic        busy     [2];
    logic        mem_en   [2];
    logic        mem_we   [2];
    logic [4:0]  mem_adr  [2];
    logic [11:0] mem_din  [2];
    logic [11:0] mem_dout [2];
    logic [11:0] mem      [2][32];

    exp_t q0[$];
    exp_t q1[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bram_single_arbiter #(.BITWIDTH(12), .RAMWIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr[0]),
        .req0(req[0][0]), .req1(req[0][1]), .we0(wen[0][0]), .we1(wen[0][1]),
        .adr0(adr[0][0]), .adr1(adr[0][1]), .din0(din[0][0]), .din1(din[0][1]),
        .ack0(ack[0][0]), .ack1(ack[0][1]), .err0(err[0][0]), .err1(err[0][1]),
        .rdata(rdata[0]), .busy(busy[0]), .mem_en(mem_en[0]), .mem_we(mem_we[0]),
        .mem_adr(mem_adr[0]), .mem_din(mem_din[0]), .mem_dout(mem_dout[0])
    );

    bram_single_arbiter #(.BITWIDTH(12), .RAMWIDTH(24)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr[1]),
        .req0(req[1][0]), .req1(req[1][1]), .we0(wen[1][0]), .we1(wen[1][1]),
        .adr0(adr[1][0]), .adr1(adr[1][1]), .din0(din[1][0]), .din1(din[1][1]),
        .ack0(ack[1][0]), .ack1(ack[1][1]), .err0(err[1][0]), .err1(err[1][1]),
        .rdata(rdata[1]), .busy(busy[1]), .mem_en(mem_en[1]), .mem_we(mem_we[1]),
        .mem_adr(mem_adr[1]), .mem_din(mem_din[1]), .mem_dout(mem_dout[1])
    );

    // BRAM model: EN low zeroes the array, writes land on the falling edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!mem_en[d]) begin
                for (int a = 0; a < 32; a++) mem[d][a] <= '0;
            end else if (mem_we[d]) begin
                mem[d][mem_adr[d]] <= mem_din[d];
            end
        end
    end
    assign mem_dout[0] = mem[0][mem_adr[0]];
    assign mem_dout[1] = mem[1][mem_adr[1]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every ACK pops the oldest expectation for that instance.
    always @(negedge clk) begin : monitor
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (ack[d][0] || ack[d][1]) begin
                check("sb_single_ack", {31'd0, ack[d][0] & ack[d][1]}, 0);
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    check("sb_unexpected_ack", 1, 0);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    check("sb_port", {31'd0, ack[d][1]}, {31'd0, e.port});
                    check("sb_err", {31'd0, err[d][e.port]}, {31'd0, e.err});
                    if (e.chk) check("sb_rdata", {20'd0, rdata[d]}, {20'd0, e.rdata});
                end
            end
        end
    end

    task automatic push(input int d, input logic p, input logic e, input logic c,
                        input logic [11:0] rd);
        exp_t x;
        x.port = p; x.err = e; x.chk = c; x.rdata = rd;
        if (d == 0) q0.push_back(x); else q1.push_back(x);
    endtask

    task automatic issue(input int d, input int p, input logic w, input logic [4:0] a,
                         input logic [11:0] dat, input logic e, input logic [11:0] rd);
        push(d, p[0], e, ~w, rd);
        wen[d][p] = w; adr[d][p] = a; din[d][p] = dat; req[d][p] = 1'b1;
    endtask

    task automatic wait_ack(input int d, input int p, output int lat, output int wecnt);
        lat = -1; wecnt = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (mem_we[d]) wecnt++;
            if (ack[d][p]) begin
                lat = i;
                req[d][p] = 1'b0;
                return;
            end
        end
        req[d][p] = 1'b0;
        check("ack_timeout", 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, wc, n;
        bit got;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            clr[d] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                req[d][p] = 1'b0; wen[d][p] = 1'b0; adr[d][p] = '0; din[d][p] = '0;
            end
        end
        repeat (3) @(negedge clk);
        check("rst_busy",    busy[0], 1);
        check("rst_mem_en",  mem_en[0], 0);
        check("rst_mem_we",  mem_we[0], 0);
        check("rst_ack",     {ack[0][0], ack[0][1], err[0][0], err[0][1]}, 0);
        check("rst_rdata",   rdata[0], 0);
        check("rst_mem_bus", {mem_adr[0], mem_din[0]}, 0);

        // 1. reset release
        rst_n = 1'b1;
        check("init_mem_en", mem_en[0], 0);
        @(negedge clk);
        check("idle_mem_en", mem_en[0], 1);
        check("idle_busy",   busy[0], 0);
        issue(0, 0, 1'b0, 5'd9, 12'h000, 1'b0, 12'h000);
        wait_ack(0, 0, lat, wc);
        check("t1_latency", lat, 3);

        // 2. write then read through the other port
        @(negedge clk);
        issue(0, 0, 1'b1, 5'd5, 12'hABC, 1'b0, 12'h000);
        wait_ack(0, 0, lat, wc);
        check("t2_wr_we_cycles", wc, 2);
        @(negedge clk);
        issue(0, 1, 1'b0, 5'd5, 12'h000, 1'b0, 12'hABC);
        wait_ack(0, 1, lat, wc);
        check("t2_rd_latency", lat, 3);
        check("t2_rd_we_cycles", wc, 0);

        // 3. both requesters held: 0,1,0,1 every 4 cycles
        @(negedge clk);
        for (int k = 0; k < 4; k++) push(0, k[0], 1'b0, 1'b1, 12'hABC);
        for (int p = 0; p < 2; p++) begin
            wen[0][p] = 1'b0; adr[0][p] = 5'd5; req[0][p] = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            got = 1'b0; n = 0;
            for (int i = 1; i <= 12 && !got; i++) begin
                @(negedge clk);
                if (ack[0][0] || ack[0][1]) begin got = 1'b1; n = i; end
            end
            check(k == 0 ? "t3_first_latency" : "t3_ack_spacing", n, k == 0 ? 3 : 4);
        end
        req[0][0] = 1'b0; req[0][1] = 1'b0;

        // 4. clear requested during ACCESS of a write
        @(negedge clk);
        issue(0, 0, 1'b1, 5'd7, 12'h123, 1'b0, 12'h000);
        @(negedge clk);
        @(negedge clk);
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        check("t4_wr_ack", ack[0][0], 1);
        req[0][0] = 1'b0;
        @(negedge clk);
        check("t4_idle_en", mem_en[0], 1);
        @(negedge clk);
        check("t4_init_en", mem_en[0], 0);
        @(negedge clk);
        check("t4_reidle_en", mem_en[0], 1);
        issue(0, 1, 1'b0, 5'd7, 12'h000, 1'b0, 12'h000);
        wait_ack(0, 1, lat, wc);
        check("t4_rd_latency", lat, 3);

        // 5. depth 24: out-of-range accesses are suppressed
        @(negedge clk);
        issue(1, 1, 1'b1, 5'd4, 12'h456, 1'b0, 12'h000);
        wait_ack(1, 1, lat, wc);
        @(negedge clk);
        issue(1, 0, 1'b0, 5'd4, 12'h000, 1'b0, 12'h456);
        wait_ack(1, 0, lat, wc);
        @(negedge clk);
        issue(1, 1, 1'b1, 5'd30, 12'h3FF, 1'b1, 12'h000);
        wait_ack(1, 1, lat, wc);
        check("t5_illegal_we_cycles", wc, 0);
        @(negedge clk);
        issue(1, 1, 1'b0, 5'd30, 12'h000, 1'b1, 12'h456);
        wait_ack(1, 1, lat, wc);
        check("t5_stale_req_latency", lat, 4);
        check("t5_rdata_hold", rdata[1], 12'h456);

        // 6. reset during ACCESS of a write
        @(negedge clk);
        wen[0][0] = 1'b1; adr[0][0] = 5'd3; din[0][0] = 12'h055; req[0][0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t6_pre_we", mem_we[0], 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_ack",     {ack[0][0], ack[0][1]}, 0);
        check("t6_busy",    busy[0], 1);
        check("t6_mem_en",  mem_en[0], 0);
        check("t6_mem_we",  mem_we[0], 0);
        check("t6_mem_bus", {mem_adr[0], mem_din[0]}, 0);
        check("t6_rdata_b", rdata[1], 0);
        req[0][0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_init_en", mem_en[0], 0);
        @(negedge clk);
        check("t6_idle_en", mem_en[0], 1);
        check("t6_idle_busy", busy[0], 0);
        repeat (4) @(negedge clk);

        check("sb_drained", q0.size() + q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
